// File: rtl/wrr_arb_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
// Weight extraction maps a programmed weight of 0 to a quantum of 1.
package wrr_arb_pkg;

    localparam int DEF_PORTS    = 4;
    localparam int DEF_WEIGHT_W = 4;
    // Upper bound on PORTS*WEIGHT_W accepted by wrr_weight().
    localparam int MAX_BUS_W    = 256;

    function automatic int unsigned wrr_weight(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          n,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0] s;
        int unsigned          v;
        s = bus >> (n * w);
        v = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < int'(w)) v[b] = s[b];
        end
        if (v == 0) v = 1;
        return v;
    endfunction

endpackage

// File: rtl/masked_priority_encoder.sv
// Pivot-exclusive round-robin priority encoder: returns the first set request
// strictly after i_pivot, wrapping, with the pivot itself checked last.
module masked_priority_encoder #(
    parameter  int PORTS = 4,
    localparam int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] i_req_vec,
    input  logic [IDX_W-1:0] i_pivot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        // Scan farthest-first so the nearest requester after the pivot wins.
        for (int k = PORTS; k >= 1; k--) begin
            int j;
            j = (int'(i_pivot) + k) % PORTS;
            if (i_req_vec[IDX_W'(j)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-port beat quantum,
// valid/ready backpressure. Define RR_LOCK_EN to let i_lock hold a grant indefinitely.
module weighted_rr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter  int PORTS    = DEF_PORTS,
    parameter  int WEIGHT_W = DEF_WEIGHT_W,
    localparam int IDX_W    = $clog2(PORTS)
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [PORTS-1:0]            i_req_vec,
    input  logic [PORTS*WEIGHT_W-1:0]   i_weight,
    input  logic                        i_ready,
    input  logic                        i_lock,
    output logic [PORTS-1:0]            o_grant_vec,
    output logic [IDX_W-1:0]            o_grant_idx,
    output logic                        o_grant_valid
);

    logic [PORTS-1:0]    r_grant_vec;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [WEIGHT_W-1:0] r_credit;
    logic [IDX_W-1:0]    r_pivot;

    logic [PORTS-1:0]    w_nxt_vec;
    logic [IDX_W-1:0]    w_nxt_idx;
    logic [WEIGHT_W-1:0] w_nxt_credit;
    logic [IDX_W-1:0]    w_nxt_pivot;

    logic                w_have_grant;
    logic                w_cur_req;
    logic                w_accept;
    logic                w_lock;
    logic                w_last;
    logic                w_hold;
    logic [IDX_W-1:0]    w_enc_pivot;
    logic [IDX_W-1:0]    w_enc_idx;
    logic                w_enc_valid;
    logic [WEIGHT_W-1:0] w_sel_weight;
    logic [MAX_BUS_W-1:0] w_weight_ext;

    // A withdrawn request drops its grant combinationally.
    assign o_grant_vec   = r_grant_vec & i_req_vec;
    assign o_grant_valid = |o_grant_vec;
    assign o_grant_idx   = o_grant_valid ? r_grant_idx : '0;

    assign w_have_grant = |r_grant_vec;
    assign w_cur_req    = w_have_grant & i_req_vec[r_grant_idx];
    assign w_accept     = o_grant_valid & i_ready;

`ifdef RR_LOCK_EN
    assign w_lock = i_lock & w_cur_req;
`else
    logic w_unused_lock;
    assign w_unused_lock = i_lock;
    assign w_lock        = 1'b0;
`endif

    assign w_last = w_accept & (r_credit == WEIGHT_W'(1)) & ~w_lock;
    assign w_hold = w_cur_req & ~w_last;

    // Rotation searches after the outgoing grantee; an idle arbiter uses the stored pivot.
    assign w_enc_pivot = w_have_grant ? r_grant_idx : r_pivot;

    masked_priority_encoder #(.PORTS(PORTS)) u_enc (
        .i_req_vec (i_req_vec),
        .i_pivot   (w_enc_pivot),
        .o_idx     (w_enc_idx),
        .o_valid   (w_enc_valid)
    );

    assign w_weight_ext = MAX_BUS_W'(i_weight);
    assign w_sel_weight = WEIGHT_W'(wrr_weight(w_weight_ext, 32'(w_enc_idx), 32'(WEIGHT_W)));

    always_comb begin
        w_nxt_vec    = r_grant_vec;
        w_nxt_idx    = r_grant_idx;
        w_nxt_credit = r_credit;
        w_nxt_pivot  = r_pivot;
        if (w_hold) begin
            if (w_accept && !w_lock) w_nxt_credit = r_credit - WEIGHT_W'(1);
        end else begin
            if (w_have_grant) w_nxt_pivot = r_grant_idx;
            if (w_enc_valid) begin
                w_nxt_vec            = '0;
                w_nxt_vec[w_enc_idx] = 1'b1;
                w_nxt_idx            = w_enc_idx;
                w_nxt_credit         = w_sel_weight;
            end else begin
                w_nxt_vec    = '0;
                w_nxt_credit = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_grant_vec <= '0;
            r_grant_idx <= '0;
            r_credit    <= '0;
            r_pivot     <= IDX_W'(PORTS - 1);
        end else begin
            r_grant_vec <= w_nxt_vec;
            r_grant_idx <= w_nxt_idx;
            r_credit    <= w_nxt_credit;
            r_pivot     <= w_nxt_pivot;
        end
    end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
- Weighted round-robin arbiter with a registered grant and a valid/ready beat handshake.
- Each port, once granted, keeps the grant for up to a programmable number of accepted beats (its quantum), then the grant rotates to the next requester.
- Successor to the plain round-robin arbiter: adds per-port weights, output backpressure and an optional lock.
- Sits in front of shared downstream resources (bus port, memory channel) that take one beat per accepted cycle.

Parameters:
- PORTS, 4: number of requesters; must be >= 2.
- WEIGHT_W, 4: width of each per-port weight and of the quantum credit counter.
- IDX_W, $clog2(PORTS): derived; width of the grant index; not for override.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_req_vec  input  PORTS  per-port request level.
- i_weight  input  PORTS*WEIGHT_W  flattened quantum per port; port n occupies bits [n*WEIGHT_W +: WEIGHT_W].
- i_ready  input  1  downstream accepts the current beat.
- i_lock  input  1  hold the current grant past its quantum; only active with RR_LOCK_EN.
- o_grant_vec  output  PORTS  one-hot grant, or zero.
- o_grant_idx  output  IDX_W  index of the current grantee; valid only when o_grant_valid=1.
- o_grant_valid  output  1  a grant is present (OR of o_grant_vec).

Behaviour:
- Reset (async assert, sync deassert):
  - registered grant = none; credit = 0; pivot = PORTS-1, so port 0 wins first.
  - o_grant_vec=0, o_grant_valid=0, o_grant_idx=0.
- Registered state: r_grant_vec (one-hot or 0), r_grant_idx, r_credit, r_pivot.
- Output masking:
  - o_grant_vec = r_grant_vec & i_req_vec, combinational.
  - A withdrawn request loses its grant in the same cycle; a non-requester is never granted.
- Accepted beat: o_grant_valid && i_ready in the same cycle.
- Next-grant selection when a new grantee is needed:
  - first set bit of i_req_vec strictly after r_pivot, wrapping around.
  - r_pivot itself is eligible last.
- Each cycle, for current grantee p:
  - HOLD if i_req_vec[p] and not (accepted beat with r_credit==1).
    - Decrement r_credit on an accepted beat.
    - i_ready low: grant, index and credit are all frozen.
  - ROTATE if i_req_vec[p] dropped, or the last credit was consumed this cycle.
    - Select the next grantee; r_pivot<=p.
  - If the selected grantee is p itself (sole requester), reload the credit and keep the grant.
- New grant:
  - registered; appears the cycle after selection (latency 1 from request or rotation).
  - r_credit loads the grantee's weight sampled at grant time.
  - A weight of 0 is treated as 1.
  - Weight changes mid-quantum take effect at the next grant.
- Idle (no grantee) with any request: select with the current r_pivot; grant at the next cycle.
- Idle with no request: stay idle; r_pivot is unchanged, so fairness continues across idle gaps.
- Simultaneous last beat and withdrawal of p: ROTATE, once.
- Fairness: with all weights 1 and all ports requesting, every port is granted once per PORTS accepted beats.

Optional Feature:
- RR_LOCK_EN defined:
  - While i_lock=1 and i_req_vec[p]=1, r_credit does not decrement and the quantum never expires.
  - Rotation then happens only on withdrawal.
  - Dropping i_lock resumes the normal quantum with the current credit.
- RR_LOCK_EN undefined: i_lock port exists but is ignored; no lock logic is synthesised.

Decomposition:
- Package wrr_arb_pkg holds:
  - the default PORTS/WEIGHT_W constants;
  - a function that extracts weight n from the flattened bus and applies the 0->1 mapping.
- Sub-module: the existing masked_priority_encoder, pivot-exclusive with wrap.
  - Inputs: i_req_vec and r_pivot.
  - Outputs: next index and valid.
- Credit counter and grant registers stay in the top module.

Test Plan:
- Reset mid-grant: assert i_rstn=0 while port 2 is granted -> o_grant_vec=0 immediately; after release with all requesting, the first grant is port 0 one cycle later.
- Equal weights: PORTS=4, weights all 1, i_req_vec=4'b1111, i_ready=1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles.
- Unequal weights: weights {3,1,2,1}, all requesting, i_ready=1 -> grants 0,0,0,1,2,2,3,0.
- Backpressure: port 1 granted with credit 2, i_ready=0 for 5 cycles -> grant and credit frozen; then 2 accepted beats -> rotates to port 2.
- Withdrawal and zero weight:
  - port 0 weight 3 drops its request after 1 beat -> o_grant_vec=0 that cycle; port 1 is granted the next cycle.
  - port with weight 0 gets exactly 1 beat.
- Sole requester and lock:
  - only port 3 requesting, weight 2 -> continuous grant, no idle cycle at quantum reload.
  - With RR_LOCK_EN, weight 1, i_lock=1, all requesting -> port 0 holds for 10 beats.
  - Without RR_LOCK_EN, same stimulus -> grant rotates every beat.
